sync_fifo_param: RTL
====================

Name: sync_fifo_param

Overview:
Parametrised single-clock FIFO. It is the successor to the fixed 8-bit FIFO used in the top-level design, with configurable width and depth. It adds occupancy count, almost-full/almost-empty thresholds, registered read data with a valid strobe, and both per-cycle pulse and sticky overflow/underflow error reporting. It sits between a producer and a consumer in the same clock domain.

Parameters:
DATA_W, 8, data word width in bits (>=1)
DEPTH, 4, number of storage entries (>=2; need not be a power of two)
AF_THRESH, 3, almost_full asserted when count >= AF_THRESH (1..DEPTH)
AE_THRESH, 1, almost_empty asserted when count <= AE_THRESH (0..DEPTH-1)
CNT_W, $clog2(DEPTH+1), width of count output (derived; not overridden)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
write_en  input  1  write request
data_in  input  DATA_W  write data
read_en  input  1  read request
data_out  output  DATA_W  registered read data; holds last value
data_valid  output  1  one-cycle strobe: data_out updated this cycle
count  output  CNT_W  current occupancy, 0..DEPTH
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= AF_THRESH
almost_empty  output  1  count <= AE_THRESH
overflow  output  1  one-cycle pulse: write rejected
underflow  output  1  one-cycle pulse: read rejected
ovf_sticky  output  1  set on any overflow, held until clr_err
udf_sticky  output  1  set on any underflow, held until clr_err
clr_err  input  1  synchronous clear of both sticky flags

Behaviour:
- Reset (reset=0, asynchronous assert, synchronous-safe deassert):
  - wr_ptr = rd_ptr = count = 0; data_out = 0.
  - data_valid, overflow, underflow, ovf_sticky, udf_sticky = 0.
  - empty = 1, almost_empty = 1, full = 0; almost_full = 0 unless AF_THRESH = 0 (illegal).
  - Storage contents are not reset.
  - Reset mid-operation discards all stored data; the first write after release goes to entry 0.
- Flags full, empty, almost_full, almost_empty are combinational from the count register and reflect state after the last edge.
- Write accepted when write_en=1 and (!full or read accepted in the same cycle). It stores data_in at wr_ptr; wr_ptr wraps from DEPTH-1 to 0 (explicit compare, not a power-of-two mask).
- Read accepted when read_en=1 and !empty, evaluated on pre-edge state.
  - Accepted read: data_out <= mem[rd_ptr] at the edge; data_valid=1 for that one cycle; rd_ptr advances with wrap. Latency is 1 clock from the read_en sample edge.
- Simultaneous read and write:
  - Not empty: both accepted; count unchanged. When full, this gives no overflow.
  - Empty: the write is accepted and the read is rejected (underflow=1). There is no write-through bypass.
- Rejected write (write_en=1, full, no accepted read): data dropped, pointers unchanged, overflow=1 for one cycle, ovf_sticky <= 1.
- Rejected read (read_en=1, empty): underflow=1 for one cycle, udf_sticky <= 1, data_out holds, data_valid=0.
- count: +1 on write-only accept, -1 on read-only accept, otherwise unchanged. It never exceeds DEPTH or goes below 0.
- clr_err=1 clears both sticky flags at the edge. A new error in the same cycle wins, so the flag stays set.
- Pulse outputs are registered and go high the cycle after the offending request edge, aligned with data_valid timing.

Test Plan:
- Reset then idle: hold reset=0 for 2 cycles, release -> count=0, empty=1, almost_empty=1, data_out=0x00, all error flags 0.
- Basic FIFO order (DEPTH=4): write 0x0A, 0x1B, 0x2C on consecutive cycles, then read 3 -> data_out sequence 0x0A, 0x1B, 0x2C, each with a data_valid pulse 1 cycle after read_en; count 3->0; almost_full=1 at count 3.
- Overflow: write 0x0A, 0x1B, 0x2C, 0x3D, 0x4E -> full=1 after the 4th write; 5th write gives overflow pulse and ovf_sticky=1; subsequent reads return 0x0A..0x3D only; clr_err clears ovf_sticky.
- Underflow / simultaneous on empty: read_en=1 when empty -> underflow pulse, udf_sticky=1, data_out unchanged. Then write 0x55 and read together while empty -> count=1, underflow pulse again, next read returns 0x55.
- Full with simultaneous read+write: fill with 0x01..0x04, then read_en=write_en=1 with data 0x05 -> no overflow, count stays 4, data_out=0x01; drain yields 0x02, 0x03, 0x04, 0x05, confirming pointer wrap.
- Reset mid-operation: write 0x0A, 0x1B, assert reset for 1 cycle -> count=0, empty=1; write 0x2C then read -> data_out=0x2C. Repeat with DEPTH=5, DATA_W=16 to check non-power-of-two wrap over 12 write/read pairs.

Source files
------------

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with registered read data, occupancy flags,
// and pulse plus sticky overflow/underflow reporting.
module sync_fifo_param #(
    parameter int   DATA_W    = 8,
    parameter int   DEPTH     = 4,
    parameter int   AF_THRESH = 3,
    parameter int   AE_THRESH = 1,
    localparam int  CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              write_en,
    input  logic [DATA_W-1:0] data_in,
    input  logic              read_en,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic              overflow,
    output logic              underflow,
    output logic              ovf_sticky,
    output logic              udf_sticky,
    input  logic              clr_err
);

    localparam int              PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              rd_acc;
    logic              wr_acc;

    assign full         = (count == CNT_W'(DEPTH));
    assign empty        = (count == '0);
    assign almost_full  = (count >= CNT_W'(AF_THRESH));
    assign almost_empty = (count <= CNT_W'(AE_THRESH));

    // A read on an empty FIFO is never accepted, so a write into an empty
    // FIFO is never bypassed to the output; a read frees a slot for a
    // same-cycle write when full.
    assign rd_acc = read_en && !empty;
    assign wr_acc = write_en && (!full || rd_acc);

    // DEPTH need not be a power of two, so wrap on an explicit compare.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    // NOTE: storage has no reset; only pointers and count define validity,
    // which keeps the array mappable to RAM.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // NOTE: all state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
            ovf_sticky <= 1'b0;
            udf_sticky <= 1'b0;
        end else begin
            data_valid <= rd_acc;
            overflow   <= write_en && !wr_acc;
            underflow  <= read_en && !rd_acc;
            // A fresh error in the clearing cycle keeps its sticky flag set.
            ovf_sticky <= (write_en && !wr_acc) || (ovf_sticky && !clr_err);
            udf_sticky <= (read_en && !rd_acc) || (udf_sticky && !clr_err);

            if (rd_acc) begin
                data_out <= mem[rd_ptr];
                rd_ptr   <= next_ptr(rd_ptr);
            end
            if (wr_acc) begin
                wr_ptr <= next_ptr(wr_ptr);
            end

            case ({wr_acc, rd_acc})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule
